// File: rtl/ad7643_slave_emulator_pkg.sv
// Shared types and constants for the AD7643 serial slave-read emulator.
// State encoding, data-source selection codes and the fixed test patterns live here.
package ad7643_slave_emulator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_READY   = 2'd2,
      ST_SHIFT   = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      PAT_SAMPLE = 2'd0,
      PAT_RAMP   = 2'd1,
      PAT_ALT    = 2'd2,
      PAT_CONST  = 2'd3
   } pattern_e;

   localparam logic [17:0] ALT_PHASE_A = 18'h2AAAA;
   localparam logic [17:0] ALT_PHASE_B = 18'h15555;
   localparam logic [17:0] CONST_CODE  = 18'h3FFFF;

   localparam int DEFAULT_BUSY_CYCLES = 160;

endpackage

// File: rtl/ad_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, followed by a one-flop edge
// detector; rise/fall pulses are one CLK wide and aligned with the synced level.
module ad_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= STAGES'({sync_q, async_i});
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  = sync_q[STAGES-1] & ~prev_q;
   assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/ad7643_slave_emulator.sv
// AD7643 serial slave-read responder: CNVST starts a timed BUSY window, then the
// selected code is shifted out MSB first on SDOUT under CS/SCLK from the master.
module ad7643_slave_emulator
   import ad7643_slave_emulator_pkg::*;
#(
   parameter int BUSY_CYCLES = DEFAULT_BUSY_CYCLES,
   parameter int DATA_W      = 18,
   parameter int RAMP_STEP   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cnvst_i,
   input  logic              cs_i,
   input  logic              sclk_i,
   input  logic [1:0]        pattern_i,
   input  logic [DATA_W-1:0] sample_i,
   output logic              busy_o,
   output logic              sdout_o,
   output logic              rderr_o,
   output logic [15:0]       conv_count_o
);

   localparam int CNT_W = $clog2(BUSY_CYCLES + 1);
   localparam int BIT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(BUSY_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [BIT_W-1:0]  BIT_MSB  = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);
   localparam logic [DATA_W-1:0] STEP     = DATA_W'(RAMP_STEP);

   logic cnvst_lvl, cnvst_rise, cnvst_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic sclk_lvl, sclk_rise, sclk_fall;

   ad_sync_edge #(.STAGES(2)) u_sync_cnvst (
      .clk(clk), .rst_n(rst_n), .async_i(cnvst_i),
      .level_o(cnvst_lvl), .rise_o(cnvst_rise), .fall_o(cnvst_fall)
   );
   ad_sync_edge #(.STAGES(2)) u_sync_cs (
      .clk(clk), .rst_n(rst_n), .async_i(cs_i),
      .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
   );
   ad_sync_edge #(.STAGES(2)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .async_i(sclk_i),
      .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );

   logic unused_sync;
   assign unused_sync = ^{cnvst_lvl, cnvst_fall, cs_rise, cs_fall, sclk_lvl, sclk_rise};

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [DATA_W-1:0] ramp_q, ramp_d;
   logic [DATA_W-1:0] phase_q, phase_d;
   logic [15:0]       count_q, count_d;
   logic              busy_q, busy_d;
   logic              sdout_q, sdout_d;
   logic              rderr_q, rderr_d;
   logic              start_conv;
   logic [DATA_W-1:0] src;
   pattern_e          pat;

   assign pat = pattern_e'(pattern_i);

   always_comb begin
      case (pat)
         PAT_SAMPLE: src = sample_i;
         PAT_RAMP:   src = ramp_q;
         PAT_ALT:    src = phase_q;
         default:    src = DATA_W'(CONST_CODE);
      endcase
   end

   // NOTE: every next-state variable gets its hold value first, so no path
   // through the case below can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shreg_d    = shreg_q;
      bit_d      = bit_q;
      ramp_d     = ramp_q;
      phase_d    = phase_q;
      count_d    = count_q;
      busy_d     = busy_q;
      rderr_d    = rderr_q;
      start_conv = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cnvst_rise) begin
               start_conv = 1'b1;
               rderr_d    = 1'b0;
            end
         end
         ST_CONVERT: begin
            if (cnvst_rise) rderr_d = 1'b1;
            if (cnt_q == '0) begin
               busy_d  = 1'b0;
               state_d = ST_READY;
               shreg_d = src;
               bit_d   = BIT_MSB;
               count_d = count_q + 16'd1;
               if (pat == PAT_RAMP) ramp_d  = ramp_q + STEP;
               if (pat == PAT_ALT)  phase_d = ~phase_q;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_READY: begin
            // CNVST wins over a simultaneous CS fall: unread data is overwritten.
            if (cnvst_rise) begin
               start_conv = 1'b1;
               rderr_d    = 1'b1;
            end else if (!cs_lvl) begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cnvst_rise) begin
               start_conv = 1'b1;
               rderr_d    = 1'b1;
            end else if (cs_lvl) begin
               state_d = ST_READY;
            end else if (sclk_fall) begin
               if (bit_q == '0) state_d = ST_IDLE;
               else             bit_d   = bit_q - BIT_ONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (start_conv) begin
         state_d = ST_CONVERT;
         busy_d  = 1'b1;
         cnt_d   = CNT_LOAD;
      end

      sdout_d = (state_d == ST_SHIFT) ? shreg_d[bit_d] : 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         bit_q   <= '0;
         ramp_q  <= '0;
         phase_q <= DATA_W'(ALT_PHASE_A);
         count_q <= '0;
         busy_q  <= 1'b0;
         sdout_q <= 1'b0;
         rderr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         bit_q   <= bit_d;
         ramp_q  <= ramp_d;
         phase_q <= phase_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         sdout_q <= sdout_d;
         rderr_q <= rderr_d;
      end
   end

   assign busy_o       = busy_q;
   assign sdout_o      = sdout_q;
   assign rderr_o      = rderr_q;
   assign conv_count_o = count_q;

endmodule

// File: tb/tb_ad7643_slave_emulator.sv
// Bench for the AD7643 emulator: a table of known codes, directed corner cases,
// then randomized conversions/reads checked against a behavioural model.
module tb_ad7643_slave_emulator;

   localparam int BUSY_CYCLES = 160;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cnvst = 1'b0;
   logic        cs = 1'b1;
   logic        sclk = 1'b0;
   logic [1:0]  pattern = 2'd0;
   logic [17:0] sample = 18'd0;

   logic        busy, sdout, rderr;
   logic [15:0] conv_count;
   logic        busy_dn, sdout_dn, rderr_dn;
   logic [15:0] conv_count_dn;

   always #4 clk = ~clk;

   ad7643_slave_emulator #(.BUSY_CYCLES(BUSY_CYCLES), .DATA_W(18), .RAMP_STEP(1)) dut (
      .clk(clk), .rst_n(rst_n), .cnvst_i(cnvst), .cs_i(cs), .sclk_i(sclk),
      .pattern_i(pattern), .sample_i(sample), .busy_o(busy), .sdout_o(sdout),
      .rderr_o(rderr), .conv_count_o(conv_count)
   );

   // Second instance steps the ramp by 2^18-1 so the modulo wrap is exercised.
   ad7643_slave_emulator #(.BUSY_CYCLES(BUSY_CYCLES), .DATA_W(18), .RAMP_STEP(18'h3FFFF)) dut_dn (
      .clk(clk), .rst_n(rst_n), .cnvst_i(cnvst), .cs_i(cs), .sclk_i(sclk),
      .pattern_i(pattern), .sample_i(sample), .busy_o(busy_dn), .sdout_o(sdout_dn),
      .rderr_o(rderr_dn), .conv_count_o(conv_count_dn)
   );

   int checks = 0;
   int errors = 0;

   logic [17:0] m_ramp, m_ramp_dn, m_phase;
   logic [15:0] m_count;
   bit          m_rderr, m_unread;
   logic [17:0] exp_up, exp_dn, w_up, w_dn;

   typedef struct {
      logic [1:0]  pat;
      logic [17:0] smp;
      logic [17:0] code;
   } vec_t;
   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ramp = '0; m_ramp_dn = '0; m_phase = 18'h2AAAA;
      m_count = '0; m_rderr = 1'b0; m_unread = 1'b0;
   endtask

   // A conversion started while earlier data is still unread flags a read error;
   // one started with nothing pending clears the flag.
   task automatic model_convert(input logic [1:0] pat, input logic [17:0] smp);
      m_rderr = m_unread;
      case (pat)
         2'd0:    exp_up = smp;
         2'd1:    exp_up = m_ramp;
         2'd2:    exp_up = m_phase;
         default: exp_up = 18'h3FFFF;
      endcase
      exp_dn = (pat == 2'd1) ? m_ramp_dn : exp_up;
      if (pat == 2'd1) begin
         m_ramp    = m_ramp + 18'd1;
         m_ramp_dn = m_ramp_dn + 18'h3FFFF;
      end
      if (pat == 2'd2) m_phase = m_phase ^ 18'h3FFFF;
      m_count  = m_count + 16'd1;
      m_unread = 1'b1;
   endtask

   task automatic do_convert(input logic [1:0] pat, input logic [17:0] smp, input bit dbl);
      int n;
      bit done;
      @(negedge clk);
      pattern = pat;
      sample  = smp;
      cnvst   = 1'b1;
      n = 0;
      done = 1'b0;
      for (int i = 0; i < 600 && !done; i++) begin
         @(negedge clk);
         if (i == 3) cnvst = 1'b0;
         if (busy) n++;
         else if (n > 0) done = 1'b1;
         if (dbl && n == 50) cnvst = 1'b1;
         if (dbl && n == 56) cnvst = 1'b0;
      end
      model_convert(pat, smp);
      if (dbl) m_rderr = 1'b1;
      check("busy_len", 32'(n), 32'(BUSY_CYCLES));
      check("conv_count", 32'(conv_count), 32'(m_count));
      check("rderr", 32'(rderr), 32'(m_rderr));
      if (cs) check("sdout_ready", 32'(sdout), 32'd0);
   endtask

   task automatic read_bits(input int nb);
      for (int i = 0; i < nb; i++) begin
         #50;
         w_up = {w_up[16:0], sdout};
         w_dn = {w_dn[16:0], sdout_dn};
         sclk = 1'b1;
         #50;
         sclk = 1'b0;
      end
      #50;
   endtask

   task automatic finish_read(input string name);
      check(name, 32'(w_up), 32'(exp_up));
      check({name, "_dn"}, 32'(w_dn), 32'(exp_dn));
      #20;
      check("sdout_after_read", 32'(sdout), 32'd0);
      cs = 1'b1;
      #100;
      m_unread = 1'b0;
   endtask

   task automatic full_read(input string name);
      w_up = '0; w_dn = '0;
      cs = 1'b0;
      read_bits(18);
      finish_read(name);
   endtask

   task automatic split_read(input int k);
      w_up = '0; w_dn = '0;
      cs = 1'b0;
      read_bits(k);
      cs = 1'b1;
      #100;
      check("sdout_paused", 32'(sdout), 32'd0);
      cs = 1'b0;
      read_bits(18 - k);
      finish_read("split_word");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      logic [1:0]  pat;
      logic [17:0] smp;
      int          op, k;
      bit          dbl;

      model_reset();
      vecs[0]  = '{2'd0, 18'h2D5A3, 18'h2D5A3};
      vecs[1]  = '{2'd1, 18'h00000, 18'h00000};
      vecs[2]  = '{2'd1, 18'h00000, 18'h00001};
      vecs[3]  = '{2'd1, 18'h00000, 18'h00002};
      vecs[4]  = '{2'd1, 18'h00000, 18'h00003};
      vecs[5]  = '{2'd1, 18'h00000, 18'h00004};
      vecs[6]  = '{2'd2, 18'h00000, 18'h2AAAA};
      vecs[7]  = '{2'd2, 18'h00000, 18'h15555};
      vecs[8]  = '{2'd2, 18'h00000, 18'h2AAAA};
      vecs[9]  = '{2'd3, 18'h12345, 18'h3FFFF};
      vecs[10] = '{2'd0, 18'h00001, 18'h00001};

      #3;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sdout", 32'(sdout), 32'd0);
      check("rst_rderr", 32'(rderr), 32'd0);
      check("rst_count", 32'(conv_count), 32'd0);
      #20 rst_n = 1'b1;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 11; i++) begin
         do_convert(vecs[i].pat, vecs[i].smp, 1'b0);
         full_read("vec_word");
         check("vec_code", 32'(w_up), 32'(vecs[i].code));
      end

      // Back-to-back conversions without a read: second overwrites, flag holds.
      do_convert(2'd0, 18'h12345, 1'b0);
      do_convert(2'd0, 18'h0ABCD, 1'b0);
      full_read("overwrite_word");
      check("rderr_hold", 32'(rderr), 32'd1);
      do_convert(2'd3, 18'h0, 1'b0);
      full_read("after_clear_word");

      do_convert(2'd2, 18'h0, 1'b1);
      full_read("dbl_word");

      do_convert(2'd3, 18'h0, 1'b0);
      split_read(9);

      do_convert(2'd0, 18'h1C3E5, 1'b0);
      split_read(9);

      cs = 1'b0;
      do_convert(2'd0, 18'h2F0F1, 1'b0);
      full_read("cs_early_word");

      // Reset asserted in the middle of a shift.
      do_convert(2'd3, 18'h0, 1'b0);
      w_up = '0; w_dn = '0;
      cs = 1'b0;
      read_bits(6);
      #50;
      sclk = 1'b1;
      #3;
      check("sdout_pre_reset", 32'(sdout), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_sdout", 32'(sdout), 32'd0);
      check("mid_rst_count", 32'(conv_count), 32'd0);
      check("mid_rst_rderr", 32'(rderr), 32'd0);
      #20 sclk = 1'b0;
      cs = 1'b1;
      #20 rst_n = 1'b1;
      model_reset();
      #40 cs = 1'b0;
      #200;
      check("sdout_post_reset", 32'(sdout), 32'd0);
      check("busy_post_reset", 32'(busy), 32'd0);
      cs = 1'b1;
      #100;

      for (int it = 0; it < 24; it++) begin
         pat = 2'($urandom_range(0, 3));
         smp = 18'($urandom);
         op  = int'($urandom_range(0, 3));
         dbl = ($urandom_range(0, 4) == 0);
         do_convert(pat, smp, dbl);
         case (op)
            0: full_read("rand_full");
            1: split_read(int'($urandom_range(1, 17)));
            2: ;
            default: begin
               k = int'($urandom_range(1, 17));
               w_up = '0; w_dn = '0;
               cs = 1'b0;
               read_bits(k);
               do_convert(2'($urandom_range(0, 3)), 18'($urandom), 1'b0);
               full_read("rand_abort");
            end
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ad7643_slave_emulator.md
Name: ad7643_slave_emulator

Overview:
- Synthesizable stand-in for the AD7643 18-bit ADC in serial slave-read mode: the responder end of the CNVST/BUSY/CS/SCLK/SDOUT interface that the capture path drives.
- Used for board bring-up and loopback via the DIGITAL PORT so the capture path can be checked against known codes without the analog front end.
- Sample codes come from an external port or an internal pattern generator.

Parameters:
- BUSY_CYCLES, 160, CLK cycles BUSY stays high per conversion (about 1.3 us at 125 MHz).
- DATA_W, 18, sample width.
- RAMP_STEP, 1, ramp increment per conversion.

Ports:
- CLK  in  1  system clock; must be at least 4x the SCLK rate.
- RSTN  in  1  asynchronous active-low reset.
- CNVST  in  1  conversion start; rising edge starts a conversion. Asynchronous to CLK.
- CS  in  1  active-low read enable. Asynchronous.
- SCLK  in  1  serial clock from the master. Asynchronous.
- BUSY  out  1  high during conversion.
- SDOUT  out  1  serial data, MSB first.
- RDERR  out  1  read-error flag.
- PATTERN  in  2  data source: 0 = SAMPLE port, 1 = ramp, 2 = alternating 0x2AAAA / 0x15555, 3 = constant 0x3FFFF.
- SAMPLE  in  DATA_W  external code; sampled at end of conversion.
- CONV_COUNT  out  16  number of completed conversions; wraps at 65535 -> 0.

Behaviour:
- Reset (RSTN low, asynchronous) clears every register and returns the FSM to IDLE:
  - BUSY=0, SDOUT=0, RDERR=0, CONV_COUNT=0.
  - Ramp register = 0; alternating-pattern phase = 0x2AAAA.
  - Reset mid-conversion or mid-shift abandons that operation; no partial data is ever presented afterwards.
- Input synchronisation: CNVST, CS and SCLK each pass through a 2-flop synchronizer, then a 1-flop edge detector. Input-to-action latency is 3 CLK.
- FSM states: IDLE, CONVERT, READY, SHIFT.
- IDLE:
  - CNVST rise -> CONVERT. BUSY goes high on the same edge the rise is detected.
  - Load busy counter with BUSY_CYCLES-1.
  - RDERR is cleared here, unless the same rise also triggers the error rule below.
- CONVERT:
  - Count down to 0; on the terminal cycle BUSY=0 and go to READY.
  - On the same edge: load shift register from the selected source, set bit index to 17, increment CONV_COUNT.
  - Ramp: the value loaded is the current ramp value; ramp then += RAMP_STEP, modulo 2^18.
  - Alternating pattern: the value loaded is the current phase; phase then toggles.
  - A CNVST rise during CONVERT is ignored and sets RDERR.
- READY:
  - If synced CS is low on entry, or falls later, go to SHIFT and drive SDOUT = bit 17 one CLK after the CS fall is detected. If CS is already low at BUSY fall, SDOUT = bit 17 on the cycle after BUSY falls.
  - A CNVST rise in READY starts a new conversion without reading (-> CONVERT) and sets RDERR (unread data overwritten).
- SHIFT:
  - Each synced SCLK falling edge with CS low decrements the bit index; SDOUT = new bit on the next CLK.
  - The master samples SDOUT on the SCLK rising edge.
  - After the 18th falling edge, SDOUT = 0 and go to IDLE.
  - CS rises before 18 bits: SDOUT=0, go to READY with the bit index held. The next CS fall resumes from that bit.
  - A CNVST rise in SHIFT aborts the read, sets RDERR and goes to CONVERT.
  - SCLK edges while CS is high are ignored in every state.
- SDOUT is 0 whenever the FSM is not in SHIFT.
- RDERR stays high until the next CNVST rise accepted from IDLE.
- Simultaneous CS fall and CNVST rise in READY: CNVST wins (go to CONVERT, set RDERR).

Decomposition:
- Shared package holds:
  - State enum {IDLE, CONVERT, READY, SHIFT}.
  - PATTERN encodings and the constants 0x2AAAA, 0x15555, 0x3FFFF.
  - DEFAULT_BUSY_CYCLES = 160.
- Sub-module: ad_sync_edge. Parameterizable 2-flop synchronizer plus rise/fall pulse outputs, instantiated 3 times.

Test Plan:
- PATTERN=0, SAMPLE=0x2D5A3; CNVST pulse, then CS low and 18 SCLK at 10 MHz -> BUSY high 160 CLK; 18 rising-edge samples read 0x2D5A3 MSB first; CONV_COUNT=1; RDERR=0.
- PATTERN=1, RAMP_STEP=1; 5 conversions each fully read -> codes 0,1,2,3,4.
- PATTERN=1 continued with ramp=0x3FFFF -> the next two reads are 0x3FFFF, then 0x00000.
- PATTERN=2; 3 full cycles -> 0x2AAAA, 0x15555, 0x2AAAA.
- Two CNVST pulses with no read between -> RDERR=1 after the second; the next read returns the second conversion's data. A following CNVST from IDLE clears RDERR.
- PATTERN=3; CS rises after 9 bits, then falls again -> read resumes at bit 8; total 18 bits = 0x3FFFF.
- RSTN low at SCLK edge 7 -> BUSY=0 and SDOUT=0 immediately; CONV_COUNT=0.
- CNVST rise during BUSY -> no BUSY extension; RDERR=1.
